// File: rtl/y86_writeback_regfile_if.sv
// y86_writeback_regfile_if
//   Bundles the signals exchanged between the SEQ pipeline stages and the
//   writeback/register-file block.
//   master : fetch/decode/execute side (drives instruction fields and results,
//            reads operands, flags and status)
//   slave  : writeback/register-file block
//   Signals:
//     icode, ifun, rA, rB        instruction fields (rA/rB = 4'hF means none)
//     cnd, alu_zf/sf/of          execute condition result and ALU flags
//     valE, valM                 execute result, memory read data
//     instr_valid, imem_error,
//     dmem_error                 per-instruction status sources
//     valA, valB                 combinational operand reads for decode
//     cc_zf, cc_sf, cc_of        registered condition codes
//     stat, halted               processor status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//     dbg_addr, dbg_data         debug register read port
interface y86_writeback_regfile_if #(
   parameter int DATA_W = 64
);
   logic [3:0]        icode;
   logic [3:0]        ifun;
   logic [3:0]        rA;
   logic [3:0]        rB;
   logic              cnd;
   logic              alu_zf;
   logic              alu_sf;
   logic              alu_of;
   logic [DATA_W-1:0] valE;
   logic [DATA_W-1:0] valM;
   logic              instr_valid;
   logic              imem_error;
   logic              dmem_error;
   logic [DATA_W-1:0] valA;
   logic [DATA_W-1:0] valB;
   logic              cc_zf;
   logic              cc_sf;
   logic              cc_of;
   logic [2:0]        stat;
   logic              halted;
   logic [3:0]        dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   modport master (
      output icode, ifun, rA, rB, cnd, alu_zf, alu_sf, alu_of, valE, valM,
             instr_valid, imem_error, dmem_error, dbg_addr,
      input  valA, valB, cc_zf, cc_sf, cc_of, stat, halted, dbg_data
   );

   modport slave (
      input  icode, ifun, rA, rB, cnd, alu_zf, alu_sf, alu_of, valE, valM,
             instr_valid, imem_error, dmem_error, dbg_addr,
      output valA, valB, cc_zf, cc_sf, cc_of, stat, halted, dbg_data
   );
endinterface

// File: rtl/y86_writeback_regfile.sv
// y86_writeback_regfile
//   Writeback end of a single-cycle Y86-64 SEQ processor. Holds the 15-entry
//   register file, the condition codes and the status register, supplies the
//   decode operands valA/valB and commits valE/valM at the end of each cycle.
//   Ports:
//     clk    system clock, all state changes on the rising edge
//     reset  synchronous active-high reset
//     wb     slave side of y86_writeback_regfile_if (see interface header)
module y86_writeback_regfile #(
   parameter int                DATA_W   = 64,
   parameter logic [DATA_W-1:0] RSP_INIT = DATA_W'(512)
) (
   input  logic                     clk,
   input  logic                     reset,
   y86_writeback_regfile_if.slave   wb
);

   typedef enum logic [2:0] {
      S_AOK = 3'd1,
      S_HLT = 3'd2,
      S_ADR = 3'd3,
      S_INS = 3'd4
   } stat_t;

   localparam logic [3:0] R_NONE = 4'hF;
   localparam logic [3:0] R_RSP  = 4'h4;

   logic [DATA_W-1:0] rf [0:14];
   logic              zf_q, sf_q, of_q;
   stat_t             stat_q;

   logic [3:0] src_a, src_b, dst_e, dst_m;
   stat_t      inst_stat;
   logic       commit;

   // ifun is not needed here: the cmov decision already arrives as cnd.
   logic unused_ifun;
   assign unused_ifun = ^wb.ifun;

   always_comb begin
      src_a = R_NONE;
      src_b = R_NONE;
      dst_e = R_NONE;
      dst_m = R_NONE;
      case (wb.icode)
         4'h2: begin
            src_a = wb.rA;
            if (wb.cnd) dst_e = wb.rB;  // cmovXX writes only when taken
         end
         4'h3: dst_e = wb.rB;
         4'h4: begin
            src_a = wb.rA;
            src_b = wb.rB;
         end
         4'h5: begin
            src_b = wb.rB;
            dst_m = wb.rA;
         end
         4'h6: begin
            src_a = wb.rA;
            src_b = wb.rB;
            dst_e = wb.rB;
         end
         4'h8: begin
            src_b = R_RSP;
            dst_e = R_RSP;
         end
         4'h9: begin
            src_a = R_RSP;
            src_b = R_RSP;
            dst_e = R_RSP;
         end
         4'hA: begin
            src_a = wb.rA;
            src_b = R_RSP;
            dst_e = R_RSP;
         end
         4'hB: begin
            src_a = R_RSP;
            src_b = R_RSP;
            dst_e = R_RSP;
            dst_m = wb.rA;
         end
         default: ;
      endcase
   end

   // Address faults outrank illegal opcodes, which outrank halt.
   always_comb begin
      inst_stat = S_AOK;
      if (wb.imem_error || wb.dmem_error) inst_stat = S_ADR;
      else if (!wb.instr_valid)           inst_stat = S_INS;
      else if (wb.icode == 4'h0)          inst_stat = S_HLT;
   end

   // A faulting/halting instruction commits nothing, nor does anything after it.
   assign commit = (stat_q == S_AOK) && (inst_stat == S_AOK);

   // Reads see pre-edge contents; no bypass from the same-cycle write.
   assign wb.valA     = (src_a == R_NONE)       ? '0 : rf[src_a];
   assign wb.valB     = (src_b == R_NONE)       ? '0 : rf[src_b];
   assign wb.dbg_data = (wb.dbg_addr == R_NONE) ? '0 : rf[wb.dbg_addr];

   assign wb.cc_zf  = zf_q;
   assign wb.cc_sf  = sf_q;
   assign wb.cc_of  = of_q;
   assign wb.stat   = stat_q;
   assign wb.halted = (stat_q != S_AOK);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 15; i++)
            rf[i] <= (i == 4) ? RSP_INIT : '0;
         zf_q   <= 1'b1;
         sf_q   <= 1'b0;
         of_q   <= 1'b0;
         stat_q <= S_AOK;
      end else begin
         if (commit) begin
            // dstM is checked first so popq %rsp keeps the popped value.
            for (int i = 0; i < 15; i++) begin
               if (dst_m == 4'(i))      rf[i] <= wb.valM;
               else if (dst_e == 4'(i)) rf[i] <= wb.valE;
            end
            if (wb.icode == 4'h6) begin
               zf_q <= wb.alu_zf;
               sf_q <= wb.alu_sf;
               of_q <= wb.alu_of;
            end
         end
         // Status is sticky once it leaves AOK.
         if (stat_q == S_AOK) stat_q <= inst_stat;
      end
   end

endmodule

// File: doc/y86_writeback_regfile.md
Name: y86_writeback_regfile

Overview:
- Consumer end of the SEQ execute stage: it commits valE, valM and cnd into architectural state.
- Holds the 15×64 register file, the condition-code register and the processor status register.
- Supplies combinational valA/valB to decode and the registered ZF/SF/OF flags that execute's condition logic uses.
- All state updates happen on the rising edge at the end of each single-cycle SEQ instruction.

Parameters:
DATA_W, 64, register and data width
RSP_INIT, 64'd512, reset value of %rsp (reg 4)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
icode  in  4  current instruction code
ifun  in  4  current function code
rA  in  4  rA field (4'hF = none)
rB  in  4  rB field (4'hF = none)
cnd  in  1  condition result from execute
alu_zf  in  1  ZF from execute ALU result
alu_sf  in  1  SF from execute ALU result
alu_of  in  1  OF from execute ALU result
valE  in  DATA_W  execute result
valM  in  DATA_W  memory read data
instr_valid  in  1  fetch decoded a legal icode
imem_error  in  1  fetch address error
dmem_error  in  1  data memory address error
valA  out  DATA_W  read of srcA (combinational)
valB  out  DATA_W  read of srcB (combinational)
cc_zf  out  1  registered ZF
cc_sf  out  1  registered SF
cc_of  out  1  registered OF
stat  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS
halted  out  1  high when stat != AOK
dbg_addr  in  4  debug read index
dbg_data  out  DATA_W  debug read of reg[dbg_addr]; 0 for index 15

Behaviour:
- Source select:
  - srcA = rA for icode 2, 4, 6, 10; srcA = 4 for icode 9, 11; else 15.
  - srcB = rB for icode 4, 5, 6; srcB = 4 for icode 8, 9, 10, 11; else 15.
- Destination select:
  - dstE = rB for icode 3 and 6, and for icode 2 only when cnd=1.
  - dstE = 4 for icode 8, 9, 10, 11; else 15.
  - dstM = rA for icode 5 and 11; else 15.
- Reads:
  - Combinational from the current register contents; index 15 reads 0.
  - No write-to-read bypass: within a cycle decode sees pre-edge values.
- Per-instruction status, in priority order:
  - imem_error or dmem_error gives ADR.
  - else instr_valid=0 gives INS.
  - else icode=0 gives HLT.
  - else AOK.
- Commit (rising edge):
  - Occurs only if the registered stat is AOK and the per-instruction status is AOK.
  - Write valE to dstE and valM to dstM; writes to index 15 are discarded.
  - When dstE == dstM (popq %rsp), valM wins.
  - The faulting or halting instruction itself commits nothing.
- CC: updated from alu_zf/alu_sf/alu_of only on commit of icode 6; otherwise held.
- Status: stat is loaded with the per-instruction status whenever the registered stat is AOK; once non-AOK it is sticky until reset.
- halted = (stat != AOK), combinational from the stat register.
- Reset:
  - Synchronous; overrides any same-edge write.
  - All registers return to 0 except reg 4 = RSP_INIT.
  - cc_zf=1, cc_sf=0, cc_of=0; stat=AOK (1); halted=0.
  - A reset asserted mid-program discards the in-flight instruction.
- Latency: a write becomes visible on valA/valB/dbg_data in the cycle after the commit edge.

Test Plan:
- Reset, then irmovq (icode 3, rB=0, valE=0x10): in the same cycle, a read of srcA=0 gives 0; after the edge, dbg reg0 = 0x10; dbg reg4 = 512.
- cmovle (icode 2, ifun 1, rB=3, valE=0x55) with cnd=0: reg3 unchanged. Repeat with cnd=1: reg3 = 0x55.
- popq %rsp (icode 11, rA=4, valE=520, valM=0x1234): reg4 = 0x1234. pushq (icode 10): valB = reg4 and reg4 = valE.
- OPq (icode 6) with alu_zf/sf/of = 0/1/0: cc becomes 0/1/0. Following irmovq with alu_zf=1: cc stays 0/1/0.
- mrmovq (icode 5, rA=1) with dmem_error=1: reg1 unchanged, stat=3, halted=1. Next irmovq: no write, stat stays 3. Reset: stat=1, reg4 = 512.
- halt (icode 0): stat=2, no writes. instr_valid=0 on a fresh run: stat=4. imem_error and instr_valid=0 together: stat=3.
